// File: rtl/uart_pkg.sv
// Types shared by the UART receive path and uart_irq_gen: receiver FSM states,
// the per-frame event bundle, and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } uart_rx_state_e;

  typedef struct packed {
    logic done;
    logic frame;
    logic parity;
    logic overrun;
  } uart_rx_evt_t;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive holding-register handshake between uart_rx (master) and its consumer (slave).
interface uart_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with majority-vote bit decisions and a one-word holding register.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      baud_tick_i,
  input  logic      rx_i,
  input  logic      stop2_i,
  input  logic      parity_en_i,
  input  logic      parity_odd_i,
  uart_rx_if.master rx_if,
  output logic      frame_err_o,
  output logic      parity_err_o,
  output logic      overrun_o,
  output logic      rx_done_o,
  output logic      busy_o
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_W + 1);

  localparam logic [TickW-1:0] TickS0   = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickS1   = TickW'(OVERSAMPLE / 2);
  localparam logic [TickW-1:0] TickVote = TickW'(OVERSAMPLE / 2 + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

  logic line;

  uart_sync2 u_sync2 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (line)
  );

  uart_rx_state_e    state_q;
  logic [TickW-1:0]  tick_q;
  logic [BitW-1:0]   bit_q;
  logic [1:0]        samp_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              stop2_q;
  logic              ferr_q;
  uart_rx_evt_t      evt_q;
`ifdef UART_RX_PARITY_EN
  logic              par_en_q;
  logic              par_odd_q;
  logic              perr_q;
`endif

  logic at_vote;
  logic at_end;
  logic vote;

  assign at_vote = baud_tick_i && (tick_q == TickVote);
  assign at_end  = baud_tick_i && (tick_q == TickLast);
  assign vote    = vote3(samp_q[0], samp_q[1], line);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stop2_q   <= 1'b0;
      ferr_q    <= 1'b0;
      evt_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      evt_q <= '0;

      if (baud_tick_i && (tick_q == TickS0)) samp_q[0] <= line;
      if (baud_tick_i && (tick_q == TickS1)) samp_q[1] <= line;
      if ((state_q != StIdle) && baud_tick_i) begin
        tick_q <= (tick_q == TickLast) ? '0 : tick_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (baud_tick_i && !line) begin
            state_q   <= StStart;
            tick_q    <= '0;
            bit_q     <= '0;
            stop2_q   <= stop2_i;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= parity_en_i;
            par_odd_q <= parity_odd_i;
            perr_q    <= 1'b0;
`endif
          end
        end
        StStart: begin
          if (at_vote && vote) begin
            state_q <= StIdle;
            tick_q  <= '0;
          end else if (at_end) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (at_vote) shift_q <= {vote, shift_q[DATA_W-1:1]};
          if (at_end) begin
            if (bit_q == BitLast) begin
              bit_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= par_en_q ? StParity : StStop1;
`else
              state_q <= StStop1;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (at_vote) perr_q <= ((^shift_q) ^ vote) != par_odd_q;
          if (at_end) state_q <= StStop1;
        end
`endif
        StStop1: begin
          if (at_vote) begin
            if (stop2_q) begin
              ferr_q <= !vote;
            end else begin
              evt_q.done  <= 1'b1;
              evt_q.frame <= !vote;
`ifdef UART_RX_PARITY_EN
              evt_q.parity <= perr_q;
`endif
              state_q <= StIdle;
              tick_q  <= '0;
            end
          end else if (at_end) begin
            state_q <= StStop2;
          end
        end
        StStop2: begin
          if (at_vote) begin
            evt_q.done  <= 1'b1;
            evt_q.frame <= ferr_q | !vote;
`ifdef UART_RX_PARITY_EN
            evt_q.parity <= perr_q;
`endif
            state_q <= StIdle;
            tick_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Word commits the cycle after the final stop vote; a same-cycle handshake frees the slot.
      if (evt_q.done) begin
        if (!valid_q || rx_if.rx_ready_i) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          evt_q.overrun <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data_o  = data_q;
  assign rx_if.rx_valid_o = valid_q;
  assign rx_done_o        = evt_q.done;
  assign frame_err_o      = evt_q.frame;
  assign overrun_o        = evt_q.overrun;
  assign busy_o           = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
  assign parity_err_o = evt_q.parity;
`else
  logic unused_parity;
  assign unused_parity = parity_en_i ^ parity_odd_i ^ evt_q.parity;
  assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from bit lists, expectations are queued at
// issue time and a monitor pops them on rx_done_o and on each holding-register handshake.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned Os      = 16;
  localparam int unsigned Dw      = 8;
  localparam int unsigned Div     = 3;
  localparam int unsigned BitClks = Os * Div;
`ifdef UART_RX_PARITY_EN
  localparam bit ParBuilt = 1'b1;
`else
  localparam bit ParBuilt = 1'b0;
`endif

  typedef struct {
    logic ferr;
    logic perr;
    logic ovr;
  } exp_evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic rx = 1'b1;
  logic stop2 = 1'b0;
  logic pen = 1'b0;
  logic podd = 1'b0;
  logic ferr, perr, ovr, done, busy;
  logic hold_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int div_cnt = 0;

  exp_evt_t        evq[$];
  logic [Dw-1:0]   dq[$];

  uart_rx_if #(.DATA_W(Dw)) rif ();

  uart_rx #(.OVERSAMPLE(Os), .DATA_W(Dw)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .baud_tick_i  (tick),
    .rx_i         (rx),
    .stop2_i      (stop2),
    .parity_en_i  (pen),
    .parity_odd_i (podd),
    .rx_if        (rif.master),
    .frame_err_o  (ferr),
    .parity_err_o (perr),
    .overrun_o    (ovr),
    .rx_done_o    (done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt == Div - 1) ? 0 : div_cnt + 1;
      tick = (div_cnt == 0);
    end
  end

  initial begin
    rif.rx_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      rif.rx_ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: samples 2ns after each rising edge; ready seen here is the value used at that edge.
  logic          m_prev_done = 1'b0;
  logic          m_prev_valid = 1'b0;
  logic [Dw-1:0] m_prev_data = '0;
  int            m_ovr_win = 0;
  logic          m_seen_ovr = 1'b0;
  logic          m_exp_ovr = 1'b0;

  initial begin
    exp_evt_t      e;
    logic [Dw-1:0] ed;
    forever begin
      @(posedge clk);
      #2;
      if (m_ovr_win > 0) begin
        m_seen_ovr = m_seen_ovr | ovr;
        m_ovr_win--;
        if (m_ovr_win == 0) check("overrun", {31'd0, m_seen_ovr}, {31'd0, m_exp_ovr});
      end else if (ovr && !done) begin
        flag("stray_overrun");
      end

      if (done) begin
        done_cnt++;
        if (m_prev_done) flag("done_pulse_width");
        if (evq.size() == 0) begin
          flag("unexpected_done");
        end else begin
          e = evq.pop_front();
          check("frame_err", {31'd0, ferr}, {31'd0, e.ferr});
          check("parity_err", {31'd0, perr}, {31'd0, e.perr});
          m_exp_ovr  = e.ovr;
          m_seen_ovr = ovr;
          m_ovr_win  = 2;
        end
      end else if (ferr || perr) begin
        flag("stray_error_pulse");
      end

      if (m_prev_valid && rif.rx_ready_i) begin
        if (dq.size() == 0) begin
          flag("unexpected_handshake");
        end else begin
          ed = dq.pop_front();
          check("rx_data", {24'd0, m_prev_data}, {24'd0, ed});
        end
      end else if (m_prev_valid) begin
        if (!rif.rx_valid_o || (rif.rx_data_o !== m_prev_data)) flag("hold_stable");
      end

      m_prev_done  = done;
      m_prev_valid = rif.rx_valid_o;
      m_prev_data  = rif.rx_data_o;
    end
  end

  task automatic send_frame(input logic [Dw-1:0] d, input logic s2, input logic pe,
                            input logic po, input logic bad_par, input logic bad_s1,
                            input logic bad_s2, input logic exp_ovr);
    logic     bits[$];
    exp_evt_t e;
    logic     par_on;
    par_on = ParBuilt && pe;
    stop2  = s2;
    pen    = pe;
    podd   = po;
    bits.push_back(1'b0);
    for (int i = 0; i < Dw; i++) bits.push_back(d[i]);
    if (par_on) bits.push_back((^d) ^ po ^ bad_par);
    bits.push_back(!bad_s1);
    if (s2) bits.push_back(!bad_s2);
    e.ferr = bad_s1 || (s2 && bad_s2);
    e.perr = par_on && bad_par;
    e.ovr  = exp_ovr;
    evq.push_back(e);
    if (!exp_ovr) dq.push_back(d);
    foreach (bits[i]) begin
      rx = bits[i];
      repeat (BitClks) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * BitClks) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((rif.rx_valid_o || dq.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flag(name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, {24'd0, rif.rx_data_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, rif.rx_valid_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pulses"}, {28'd0, done, ferr, perr, ovr}, 32'd0);
  endtask

  initial begin
    int            d0;
    logic [Dw-1:0] w;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2 * BitClks) @(negedge clk);

    // 8N1 0xA5 held in the register.
    hold_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a5_valid", {31'd0, rif.rx_valid_o}, 32'd1);
    check("a5_data", {24'd0, rif.rx_data_o}, 32'hA5);
    hold_ready = 1'b0;
    drain("drain_a5");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Bad stop bit, then good first / bad second stop with two stop bits.
    send_frame(8'h3E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("drain_stop");

    // Short low glitch on the idle line.
    d0 = done_cnt;
    rx = 1'b0;
    repeat (3 * Div) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (2 * BitClks) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_no_done", done_cnt, d0);

    // Overrun: second word dropped while the first is still unread.
    hold_ready = 1'b1;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_valid", {31'd0, rif.rx_valid_o}, 32'd1);
    check("ovr_data", {24'd0, rif.rx_data_o}, 32'h11);
    hold_ready = 1'b0;
    drain("drain_ovr");

    // Reset in the middle of data bit 4.
    w = 8'h5A;
    stop2 = 1'b0;
    pen = 1'b0;
    rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = w[i];
      repeat (BitClks) @(negedge clk);
    end
    rx = w[4];
    repeat (BitClks / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("midreset");
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BitClks) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("drain_3c");

    for (int n = 0; n < 24; n++) begin
      send_frame(Dw'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), 1'b0);
    end
    drain("drain_random");
    repeat (BitClks) @(negedge clk);
    check("events_left", evq.size(), 32'd0);
    check("words_left", dq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
